// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scanner
// Description : Multiplexed seven-segment scan driver. Captures packed BCD
//               digits into a shadow register at frame boundaries, then scans
//               them onto a shared segment bus with guard blanking and
//               optional leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int GUARD          = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    input  logic                          blank_lz,
    output logic [6:0]                    seg_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_done
);

    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_PW    = $clog2(REFRESH_DIV + 1);

    localparam logic [c_PW-1:0]    c_TC      = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_PW-1:0]    c_GUARD   = c_PW'(GUARD);
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic               c_SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic               c_AN_INV  = (AN_ACTIVE_LOW != 0);

    logic [c_PW-1:0]         r_presc;
    logic [4*NUM_DIGITS-1:0] r_stage_bcd;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_blank_vec;
    logic                    w_zero_run;
    logic [3:0]              w_digit;
    logic                    w_dp;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an_hi;
    logic [6:0]              w_seg_hi;

    assign w_slot_end = (r_presc == c_TC);
    assign w_wrap     = w_slot_end && (scan_idx == c_LAST);
    // The wrap edge is the frame boundary; the pulse marks the cycle ending there.
    assign frame_done = w_wrap;

    // Prescaler and slot index: one slot per REFRESH_DIV cycles, wrapping per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            scan_idx <= '0;
        end else if (w_slot_end) begin
            r_presc  <= '0;
            scan_idx <= w_wrap ? '0 : scan_idx + 1'b1;
        end else begin
            r_presc  <= r_presc + 1'b1;
        end
    end

    // Staging/shadow capture: shadow only updates on the wrap edge so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_bcd  <= '0;
            r_stage_dp   <= '0;
            r_pending    <= 1'b0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
        end else begin
            if (load) begin
                r_stage_bcd <= bcd_in;
                r_stage_dp  <= dp_in;
            end
            if (w_wrap) begin
                // A load coinciding with the wrap bypasses staging directly.
                if (load) begin
                    r_shadow_bcd <= bcd_in;
                    r_shadow_dp  <= dp_in;
                end else if (r_pending) begin
                    r_shadow_bcd <= r_stage_bcd;
                    r_shadow_dp  <= r_stage_dp;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Leading-zero mask: digit i is a candidate when it and every digit above are zero.
    always_comb begin
        w_zero_run  = 1'b1;
        w_blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (r_shadow_bcd[i*4 +: 4] == 4'd0);
            if (i > 0) begin
                w_blank_vec[i] = w_zero_run;
            end
        end
    end

    // Select the digit, decimal point, blank flag and anode for the current slot.
    always_comb begin
        w_digit = 4'd0;
        w_dp    = 1'b0;
        w_blank = 1'b0;
        w_an_hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == c_IDX_W'(i)) begin
                w_digit    = r_shadow_bcd[i*4 +: 4];
                w_dp       = r_shadow_dp[i];
                w_blank    = blank_lz & w_blank_vec[i];
                w_an_hi[i] = 1'b1;
            end
        end
    end

    // BCD to seven-segment, active-high {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    always_comb begin
        w_seg_hi = 7'h40;
        case (w_digit)
            4'd0:    w_seg_hi = 7'h3F;
            4'd1:    w_seg_hi = 7'h06;
            4'd2:    w_seg_hi = 7'h5B;
            4'd3:    w_seg_hi = 7'h4F;
            4'd4:    w_seg_hi = 7'h66;
            4'd5:    w_seg_hi = 7'h6D;
            4'd6:    w_seg_hi = 7'h7D;
            4'd7:    w_seg_hi = 7'h07;
            4'd8:    w_seg_hi = 7'h7F;
            4'd9:    w_seg_hi = 7'h6F;
            default: w_seg_hi = 7'h40;
        endcase
    end

    // Registered display outputs: dark during the guard window and for blanked digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_out  <= {NUM_DIGITS{c_AN_INV}};
            seg_out <= {7{c_SEG_INV}};
            dp_out  <= c_SEG_INV;
        end else if ((r_presc < c_GUARD) || w_blank) begin
            an_out  <= {NUM_DIGITS{c_AN_INV}};
            seg_out <= {7{c_SEG_INV}};
            dp_out  <= c_SEG_INV;
        end else begin
            an_out  <= w_an_hi ^ {NUM_DIGITS{c_AN_INV}};
            seg_out <= w_seg_hi ^ {7{c_SEG_INV}};
            dp_out  <= w_dp ^ c_SEG_INV;
        end
    end

endmodule
`default_nettype wire
